// File: rtl/serializer.sv
// Byte-to-bit serializer: loads a byte on request, shifts it out one bit per
// cycle (optional even-parity trailer), honours a stall input, then signals done.
module serializer #(
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic       clk_100khz,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       pause_in,
    output logic       data_out,
    output logic       write_out,
    output logic       ack_out,
    output logic       status_out,
    output logic       done_out
);

    localparam logic [3:0] FRAME_LEN = 4'(8 + PARITY_EN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic       parity_q, parity_d;
    logic [3:0] cnt_q, cnt_d;
    logic       data_out_q, data_out_d;
    logic       write_q, write_d;
    logic       ack_q, ack_d;
    logic       status_q, status_d;
    logic       done_q, done_d;
    logic       next_bit_s;

    // State register
    always_ff @(posedge clk_100khz or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!pause_in && (cnt_q == (FRAME_LEN - 4'd1))) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The parity trailer occupies slot 8, after all data bits have left the register
    always_comb begin
        next_bit_s = 1'b0;
        if (cnt_q == 4'd8) begin
            next_bit_s = parity_q;
        end else if (MSB_FIRST != 0) begin
            next_bit_s = shreg_q[7];
        end else begin
            next_bit_s = shreg_q[0];
        end
    end

    // Datapath and output next values
    always_comb begin
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        write_d    = 1'b0;
        ack_d      = 1'b0;
        done_d     = 1'b0;
        status_d   = status_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    shreg_d  = data_in;
                    parity_d = even_parity(data_in);
                    cnt_d    = 4'd0;
                    ack_d    = 1'b1;
                    status_d = 1'b0;
                end else begin
                    status_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                status_d = 1'b0;
                if (!pause_in) begin
                    data_out_d = next_bit_s;
                    write_d    = 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                    if (MSB_FIRST != 0) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end else begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    write_d = 1'b0;
                end
            end
            ST_FINISH: begin
                done_d   = 1'b1;
                status_d = 1'b1;
            end
            default: begin
                status_d = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_100khz or posedge reset) begin
        if (reset) begin
            shreg_q    <= 8'h00;
            parity_q   <= 1'b0;
            cnt_q      <= 4'd0;
            data_out_q <= 1'b0;
            write_q    <= 1'b0;
            ack_q      <= 1'b0;
            status_q   <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            write_q    <= write_d;
            ack_q      <= ack_d;
            status_q   <= status_d;
            done_q     <= done_d;
        end
    end

    assign data_out   = data_out_q;
    assign write_out  = write_q;
    assign ack_out    = ack_q;
    assign status_out = status_q;
    assign done_out   = done_q;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: two instances (MSB-first/no parity, LSB-first/parity)
// checked cycle by cycle against an expected-bit-stream model.
`timescale 1ns/1ps
module tb_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] din  [2];
    logic       dv   [2];
    logic       pz   [2];
    logic       dout [2];
    logic       wout [2];
    logic       ack  [2];
    logic       stat [2];
    logic       done [2];
    logic       last_out [2];
    int         checks;
    int         failures;

    serializer #(.MSB_FIRST(1), .PARITY_EN(0)) dut0 (
        .clk_100khz(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
        .pause_in(pz[0]), .data_out(dout[0]), .write_out(wout[0]), .ack_out(ack[0]),
        .status_out(stat[0]), .done_out(done[0]));

    serializer #(.MSB_FIRST(0), .PARITY_EN(1)) dut1 (
        .clk_100khz(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
        .pause_in(pz[1]), .data_out(dout[1]), .write_out(wout[1]), .ack_out(ack[1]),
        .status_out(stat[1]), .done_out(done[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected i-th bit of a frame, straight from the bit-order/parity rules.
    function automatic logic exp_bit(input int idx, input logic [7:0] b, input int i);
        if (i == 8) return ^b;
        if (idx == 0) return b[7 - i];
        return b[i];
    endfunction

    task automatic chk_reset_vals(input int idx, input string tag);
        check($sformatf("%s_d%0d_dout", tag, idx), 32'(dout[idx]), 32'd0);
        check($sformatf("%s_d%0d_wr", tag, idx), 32'(wout[idx]), 32'd0);
        check($sformatf("%s_d%0d_ack", tag, idx), 32'(ack[idx]), 32'd0);
        check($sformatf("%s_d%0d_done", tag, idx), 32'(done[idx]), 32'd0);
        check($sformatf("%s_d%0d_stat", tag, idx), 32'(stat[idx]), 32'd1);
    endtask

    task automatic idle(input int idx, input int n);
        for (int k = 0; k < n; k++) begin
            dv[idx] = 1'b0;
            din[idx] = 8'($urandom);
            pz[idx] = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("idle_d%0d_stat", idx), 32'(stat[idx]), 32'd1);
            check($sformatf("idle_d%0d_wr", idx), 32'(wout[idx]), 32'd0);
            check($sformatf("idle_d%0d_ack", idx), 32'(ack[idx]), 32'd0);
            check($sformatf("idle_d%0d_done", idx), 32'(done[idx]), 32'd0);
        end
    endtask

    // mode: 0 = no pause, 1 = random pauses, 2 = 3-cycle pause after the 2nd bit.
    // hold: keep data_valid high with nb during the frame (busy / back-to-back).
    task automatic frame(input int idx, input logic [7:0] b, input int mode,
                         input bit hold, input logic [7:0] nb);
        int   n;
        int   emitted;
        int   paused;
        int   iters;
        logic p;
        logic e;
        n = (idx == 0) ? 8 : 9;
        emitted = 0;
        paused = 0;
        iters = 0;
        din[idx] = b;
        dv[idx] = 1'b1;
        pz[idx] = 1'($urandom_range(0, 1));
        tick();
        check($sformatf("acc_%0h_ack", b), 32'(ack[idx]), 32'd1);
        check($sformatf("acc_%0h_stat", b), 32'(stat[idx]), 32'd0);
        check($sformatf("acc_%0h_wr", b), 32'(wout[idx]), 32'd0);
        check($sformatf("acc_%0h_done", b), 32'(done[idx]), 32'd0);
        check($sformatf("acc_%0h_dout", b), 32'(dout[idx]), 32'(last_out[idx]));
        dv[idx] = hold;
        din[idx] = hold ? nb : 8'($urandom);
        while (emitted < n && iters < 64) begin
            iters++;
            if (mode == 2) p = (emitted == 2) && (paused < 3);
            else if (mode == 1) p = ($urandom_range(0, 3) == 0);
            else p = 1'b0;
            pz[idx] = p;
            tick();
            check($sformatf("sh_%0h_ack", b), 32'(ack[idx]), 32'd0);
            check($sformatf("sh_%0h_stat", b), 32'(stat[idx]), 32'd0);
            check($sformatf("sh_%0h_done", b), 32'(done[idx]), 32'd0);
            if (p) begin
                paused++;
                check($sformatf("pz_%0h_wr", b), 32'(wout[idx]), 32'd0);
                check($sformatf("pz_%0h_dout", b), 32'(dout[idx]), 32'(last_out[idx]));
            end else begin
                e = exp_bit(idx, b, emitted);
                check($sformatf("bit_%0h_%0d_wr", b, emitted), 32'(wout[idx]), 32'd1);
                check($sformatf("bit_%0h_%0d_val", b, emitted), 32'(dout[idx]), 32'(e));
                last_out[idx] = e;
                emitted++;
            end
        end
        if (emitted < n) check($sformatf("timeout_%0h", b), 32'(emitted), 32'(n));
        pz[idx] = 1'($urandom_range(0, 1));
        tick();
        check($sformatf("fin_%0h_wr", b), 32'(wout[idx]), 32'd0);
        check($sformatf("fin_%0h_done", b), 32'(done[idx]), 32'd1);
        check($sformatf("fin_%0h_stat", b), 32'(stat[idx]), 32'd1);
        check($sformatf("fin_%0h_ack", b), 32'(ack[idx]), 32'd0);
        check($sformatf("fin_%0h_dout", b), 32'(dout[idx]), 32'(last_out[idx]));
    endtask

    task automatic reset_mid(input int idx, input logic [7:0] b);
        din[idx] = b;
        dv[idx] = 1'b1;
        pz[idx] = 1'b0;
        tick();
        check("rm_ack", 32'(ack[idx]), 32'd1);
        dv[idx] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rm_bit%0d", i), 32'(dout[idx]), 32'(exp_bit(idx, b, i)));
            check($sformatf("rm_wr%0d", i), 32'(wout[idx]), 32'd1);
        end
        reset = 1'b1;
        #1;
        chk_reset_vals(idx, "rm_async");
        tick();
        chk_reset_vals(idx, "rm_held");
        reset = 1'b0;
        last_out[0] = 1'b0;
        last_out[1] = 1'b0;
        idle(idx, 12);
    endtask

    initial begin
        bit         hold;
        bit         prev_hold;
        logic [7:0] b;
        logic [7:0] nb;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din[i] = 8'h00;
            dv[i] = 1'b0;
            pz[i] = 1'b0;
            last_out[i] = 1'b0;
        end
        tick();
        tick();
        chk_reset_vals(0, "rst");
        chk_reset_vals(1, "rst");
        reset = 1'b0;
        idle(0, 2);
        idle(1, 2);

        frame(0, 8'hA5, 0, 1'b0, 8'h00);
        idle(0, 2);
        frame(1, 8'h03, 0, 1'b0, 8'h00);
        idle(1, 2);
        frame(0, 8'hF0, 2, 1'b0, 8'h00);
        idle(0, 1);
        frame(0, 8'hA5, 0, 1'b1, 8'h55);
        frame(0, 8'h55, 0, 1'b0, 8'h00);
        idle(0, 1);
        reset_mid(0, 8'hA5);
        frame(0, 8'h81, 0, 1'b0, 8'h00);
        idle(0, 1);
        frame(0, 8'h12, 0, 1'b1, 8'h34);
        frame(0, 8'h34, 0, 1'b0, 8'h00);
        idle(0, 1);
        reset_mid(1, 8'h5C);
        frame(1, 8'h81, 1, 1'b0, 8'h00);

        for (int idx = 0; idx < 2; idx++) begin
            prev_hold = 1'b0;
            nb = 8'($urandom);
            for (int k = 0; k < 12; k++) begin
                b = prev_hold ? nb : 8'($urandom);
                hold = (k == 11) ? 1'b0 : 1'($urandom_range(0, 1));
                nb = 8'($urandom);
                frame(idx, b, 1, hold, nb);
                if (!hold) idle(idx, $urandom_range(1, 3));
                prev_hold = hold;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
